cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_defs_pkg.sv | 33 +++
 rtl/op_classify.sv | 39 +++
 rtl/cpu_sequencer.sv | 173 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the CPU sequencer and control unit: state encodings,
// the nine recognised opcode values (instr[6:2]) and opcode-class helpers.
package cpu_defs;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } seq_state_t;

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;

    localparam int TMO_W = 4;

    // Stores and branches are the only legal classes that leave the register file untouched.
    function automatic logic writes_reg(input logic legal, input logic is_store,
                                        input logic is_branch);
        return legal & ~is_store & ~is_branch;
    endfunction

endpackage

// File: rtl/op_classify.sv
// Combinational opcode classifier: maps instr[6:2] to load/store/branch/legal flags.
module op_classify
    import cpu_defs::*;
(
    input  logic [4:0] op,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       legal
);

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        legal     = 1'b0;
        case (op)
            OP_LOAD: begin
                is_load = 1'b1;
                legal   = 1'b1;
            end
            OP_STORE: begin
                is_store = 1'b1;
                legal    = 1'b1;
            end
            OP_BRANCH: begin
                is_branch = 1'b1;
                legal     = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_OPIMM, OP_OP, OP_JAL, OP_JALR: begin
                legal = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer. Define SEQ_TIMEOUT_EN to enable the
// 16-cycle memory-handshake timeout that traps with bus_err.
//
//  state  | meaning
//  IDLE   | waiting for start
//  FETCH  | imem_req high until imem_ack; ir_we on ack
//  DECODE | legality check of op
//  EXEC   | route: load/store -> MEM, branch retires, else -> WB
//  MEM    | dmem_req high until dmem_ack; store retires on ack
//  WB     | rf_we/pc_we pulse, retire
//  TRAP   | illegal opcode or bus timeout, left only by rst
module cpu_sequencer
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt,
    input  logic [4:0]  op,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic        busy,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state,
    output logic [31:0] retire_cnt
);

    seq_state_t  st;
    logic [31:0] ret_cnt_q;
    logic        pc_we_q;
    logic        rf_we_q;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        legal;
    logic        regwr;
    logic        fetch_done;
    logic        mem_done;
    logic        retire;
    logic        tmo_trap;

    op_classify u_classify (
        .op        (op),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_branch (is_branch),
        .legal     (legal)
    );

    assign regwr      = writes_reg(legal, is_store, is_branch);
    assign fetch_done = (st == ST_FETCH) && imem_ack;
    assign mem_done   = (st == ST_MEM) && dmem_ack;
    assign retire     = ((st == ST_EXEC) && is_branch)
                      || (mem_done && is_store)
                      || (st == ST_WB);

`ifdef SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             waiting;
    logic             bus_err_q;

    assign waiting  = ((st == ST_FETCH) && !imem_ack) || ((st == ST_MEM) && !dmem_ack);
    assign tmo_trap = waiting && (tmo_cnt == {TMO_W{1'b1}});
    assign bus_err  = bus_err_q;

    // Any exit from FETCH/MEM happens on an ack or a trap, so the count is
    // already zero whenever one of those states is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_cnt <= waiting ? tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1} : '0;
            if (tmo_trap) begin
                bus_err_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_trap = 1'b0;
    assign bus_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ST_IDLE;
            ret_cnt_q <= '0;
            pc_we_q   <= 1'b0;
            rf_we_q   <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            pc_we_q <= 1'b0;
            rf_we_q <= 1'b0;
            if (retire) begin
                ret_cnt_q <= ret_cnt_q + 32'd1;
            end
            case (st)
                ST_IDLE: begin
                    if (start) begin
                        st <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        st <= ST_DECODE;
                    end else if (tmo_trap) begin
                        st <= ST_TRAP;
                    end
                end
                ST_DECODE: begin
                    if (legal) begin
                        st      <= ST_EXEC;
                        pc_we_q <= is_branch;
                    end else begin
                        st      <= ST_TRAP;
                        illegal <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (is_load || is_store) begin
                        st <= ST_MEM;
                    end else if (is_branch) begin
                        st <= halt ? ST_IDLE : ST_FETCH;
                    end else begin
                        st      <= ST_WB;
                        pc_we_q <= 1'b1;
                        rf_we_q <= regwr;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        if (is_store) begin
                            st <= halt ? ST_IDLE : ST_FETCH;
                        end else begin
                            st      <= ST_WB;
                            pc_we_q <= 1'b1;
                            rf_we_q <= regwr;
                        end
                    end else if (tmo_trap) begin
                        st <= ST_TRAP;
                    end
                end
                ST_WB: begin
                    st <= halt ? ST_IDLE : ST_FETCH;
                end
                ST_TRAP: begin
                    st <= ST_TRAP;
                end
                default: begin
                    st <= ST_TRAP;
                end
            endcase
        end
    end

    assign state      = st;
    assign retire_cnt = ret_cnt_q;
    assign busy       = (st != ST_IDLE);
    assign imem_req   = (st == ST_FETCH);
    assign ir_we      = fetch_done;
    assign dmem_req   = (st == ST_MEM);
    assign dmem_we    = (st == ST_MEM) && is_store;
    assign pc_we      = pc_we_q | (mem_done & is_store);
    assign rf_we      = rf_we_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus a randomized
// instruction stream checked against per-instruction latency/strobe rules.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, halt, imem_ack, dmem_ack;
    logic [4:0]  op;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
    logic        busy, illegal, bus_err;
    logic [2:0]  state;
    logic [31:0] retire_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_ret;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .halt       (halt),
        .op         (op),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .rf_we      (rf_we),
        .busy       (busy),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .state      (state),
        .retire_cnt (retire_cnt)
    );

    function automatic logic [4:0] legal_op(input int idx);
        case (idx)
            0: return 5'b01101;
            1: return 5'b00101;
            2: return 5'b00100;
            3: return 5'b01100;
            4: return 5'b11011;
            5: return 5'b11001;
            6: return 5'b11000;
            7: return 5'b00000;
            default: return 5'b01000;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; halt = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        tick();
        rst = 1'b0;
        exp_ret = 32'd0;
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs one instruction starting in FETCH. Expected behaviour comes from the
    // architectural rules: latency per class plus ack wait cycles, one ir_we,
    // one pc_we in the final (retire) cycle, rf_we only for register writers.
    task automatic exec_instr(input logic [4:0] o, input int di, input int dm,
                              input logic hlt, input logic rnd_start, input string tag);
        int  cyc, fseen, mseen, n_ir, n_pc, n_rf, n_dreq, n_dwe, ir_at, pc_at, rf_at, lat;
        bit  done, is_ld, is_st, is_br, wr;
        is_ld = (o == 5'b00000);
        is_st = (o == 5'b01000);
        is_br = (o == 5'b11000);
        wr    = !is_st && !is_br;
        lat   = (is_br ? 3 : (is_ld ? 5 : 4)) + di + ((is_ld || is_st) ? dm : 0);
        cyc = 0; fseen = 0; mseen = 0; n_ir = 0; n_pc = 0; n_rf = 0; n_dreq = 0; n_dwe = 0;
        ir_at = -1; pc_at = -1; rf_at = -1; done = 0;
        op = o; halt = hlt;
        while (!done && cyc < 64) begin
            start    = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_ack = imem_req ? (fseen == di) : 1'($urandom_range(0, 1));
            dmem_ack = dmem_req ? (mseen == dm) : 1'($urandom_range(0, 1));
            #1;
            if (imem_req) fseen++;
            if (dmem_req) begin mseen++; n_dreq++; end
            if (dmem_we) n_dwe++;
            if (ir_we) begin n_ir++; if (ir_at < 0) ir_at = cyc; end
            if (pc_we) begin n_pc++; if (pc_at < 0) pc_at = cyc; end
            if (rf_we) begin n_rf++; if (rf_at < 0) rf_at = cyc; end
            tick();
            cyc++;
            if (n_ir > 0 && (state == 3'd1 || state == 3'd0 || state == 3'd6)) done = 1;
        end
        start = 1'b0; halt = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        exp_ret = exp_ret + 32'd1;
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL %s completion: no retire within 64 cycles", tag); end
        n_cmp++;
        if (cyc !== lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", tag, cyc, lat); end
        n_cmp++;
        if (n_ir !== 1 || ir_at !== di) begin
            n_bad++; $display("FAIL %s ir_we: got %0d pulses at %0d want 1 at %0d", tag, n_ir, ir_at, di);
        end
        n_cmp++;
        if (n_pc !== 1 || pc_at !== lat - 1) begin
            n_bad++; $display("FAIL %s pc_we: got %0d pulses at %0d want 1 at %0d", tag, n_pc, pc_at, lat - 1);
        end
        n_cmp++;
        if (n_rf !== (wr ? 1 : 0) || (wr && rf_at !== lat - 1)) begin
            n_bad++; $display("FAIL %s rf_we: got %0d pulses at %0d want %0d at %0d", tag, n_rf, rf_at, wr ? 1 : 0, lat - 1);
        end
        n_cmp++;
        if (n_dreq !== ((is_ld || is_st) ? dm + 1 : 0) || n_dwe !== (is_st ? dm + 1 : 0)) begin
            n_bad++; $display("FAIL %s dmem: got req %0d we %0d want req %0d we %0d", tag, n_dreq, n_dwe,
                              (is_ld || is_st) ? dm + 1 : 0, is_st ? dm + 1 : 0);
        end
        n_cmp++;
        if (state !== (hlt ? 3'd0 : 3'd1)) begin
            n_bad++; $display("FAIL %s next_state: got %0d want %0d", tag, state, hlt ? 0 : 1);
        end
        n_cmp++;
        if (retire_cnt !== exp_ret) begin
            n_bad++; $display("FAIL %s retire_cnt: got %0h want %0h", tag, retire_cnt, exp_ret);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; halt = 1'b1; op = 5'b01100; imem_ack = 1'b1; dmem_ack = 1'b1;
        tick(); tick();
        start = 1'b0; halt = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        n_cmp++;
        if (state !== 3'd0 || retire_cnt !== 32'd0 || illegal !== 1'b0 || bus_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_regs: state %0d cnt %0h ill %0b berr %0b want 0 0 0 0",
                              state, retire_cnt, illegal, bus_err);
        end
        n_cmp++;
        if ({imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, busy} !== 7'd0) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 0000000",
                              {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, busy});
        end
        rst = 1'b0;
        exp_ret = 32'd0;
        tick();
        n_cmp++;
        if (state !== 3'd0) begin n_bad++; $display("FAIL idle_hold: state %0d want 0", state); end
    endtask

    task automatic test_alu();
        apply_reset();
        op = 5'b01100;
        kick();
        n_cmp++;
        if (state !== 3'd1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL start_fetch: state %0d busy %0b want 1 1", state, busy);
        end
        exec_instr(5'b01100, 0, 0, 1'b0, 1'b0, "alu");
    endtask

    task automatic test_load_wait();
        exec_instr(5'b00000, 0, 3, 1'b0, 1'b1, "load_wait");
    endtask

    task automatic test_store();
        exec_instr(5'b01000, 0, 0, 1'b0, 1'b1, "store");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [4:0] o;
            logic       h;
            o = legal_op(int'($urandom_range(0, 8)));
            h = ($urandom_range(0, 4) == 0);
            exec_instr(o, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), h, 1'b1, "random");
            if (h) kick();
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        kick();
        op = 5'b11111; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        #1;
        n_cmp++;
        if (state !== 3'd6 || illegal !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL illegal_trap: state %0d ill %0b busy %0b want 6 1 1", state, illegal, busy);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            start = 1'b1; halt = 1'($urandom_range(0, 1));
            imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (state !== 3'd6 || {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we} !== 6'd0) begin
                n_bad++; $display("FAIL trap_hold: state %0d strobes %b want 6 000000", state,
                                  {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we});
            end
        end
        tick();
        apply_reset();
        #1;
        n_cmp++;
        if (state !== 3'd0 || illegal !== 1'b0) begin
            n_bad++; $display("FAIL trap_exit: state %0d ill %0b want 0 0", state, illegal);
        end
        tick();
    endtask

    task automatic test_wrap_halt();
        apply_reset();
        force dut.ret_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.ret_cnt_q;
        exp_ret = 32'hFFFF_FFFF;
        kick();
        exec_instr(5'b11000, 0, 0, 1'b1, 1'b0, "wrap_halt");
        tick();
        n_cmp++;
        if (state !== 3'd0 || retire_cnt !== 32'd0) begin
            n_bad++; $display("FAIL halt_stays_idle: state %0d cnt %0h want 0 0", state, retire_cnt);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        kick();
        tick(); tick();
        rst = 1'b1;
        tick();
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || state !== 3'd0 || retire_cnt !== 32'd0) begin
            n_bad++; $display("FAIL reset_in_fetch: req %0b state %0d cnt %0h want 0 0 0", imem_req, state, retire_cnt);
        end
        rst = 1'b0;
        tick();
        kick();
        op = 5'b00000; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick(); tick();
        n_cmp++;
        if (dmem_req !== 1'b1) begin n_bad++; $display("FAIL mem_reached: dmem_req %0b want 1", dmem_req); end
        rst = 1'b1;
        tick();
        #1;
        n_cmp++;
        if (dmem_req !== 1'b0 || state !== 3'd0 || retire_cnt !== 32'd0 || rf_we !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_mem: req %0b state %0d cnt %0h rf %0b want 0 0 0 0",
                              dmem_req, state, retire_cnt, rf_we);
        end
        rst = 1'b0;
        exp_ret = 32'd0;
        tick();
    endtask

    task automatic test_timeout();
        int n_f;
        apply_reset();
        kick();
        n_f = 0;
        while (state == 3'd1 && n_f < 40) begin
            imem_ack = 1'b0;
            tick();
            n_f++;
        end
`ifdef SEQ_TIMEOUT_EN
        n_cmp++;
        if (n_f !== 16 || state !== 3'd6 || bus_err !== 1'b1 || imem_req !== 1'b0) begin
            n_bad++; $display("FAIL timeout_trap: fetch cycles %0d state %0d berr %0b want 16 6 1", n_f, state, bus_err);
        end
        apply_reset();
        kick();
        for (int i = 0; i < 16; i++) begin
            imem_ack = (i == 15);
            tick();
        end
        imem_ack = 1'b0;
        n_cmp++;
        if (state !== 3'd2 || bus_err !== 1'b0) begin
            n_bad++; $display("FAIL timeout_ack_wins: state %0d berr %0b want 2 0", state, bus_err);
        end
`else
        n_cmp++;
        if (n_f !== 40 || state !== 3'd1 || bus_err !== 1'b0) begin
            n_bad++; $display("FAIL no_timeout: fetch cycles %0d state %0d berr %0b want 40 1 0", n_f, state, bus_err);
        end
`endif
        apply_reset();
    endtask

    initial begin
        op = 5'd0; rst = 1'b1; start = 1'b0; halt = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        exp_ret = 32'd0;
        tick();
        test_reset();
        test_alu();
        test_load_wait();
        test_store();
        test_random();
        test_illegal();
        test_wrap_halt();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
